// File: rtl/word_serializer_pkg.sv
// Shared definitions for the word serializer: FSM state encoding and counter sizing.
//   ser_state_t : ST_IDLE=0, ST_SHIFT=1, ST_GAP=2; encoding 3 is unused and recovers to ST_IDLE
//   cnt_width() : bits needed for a down counter that is loaded with at most n-1
package word_serializer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } ser_state_t;

   // A counter that is loaded with at most n-1 needs $clog2(n) bits (minimum 1).
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ser_down_counter.sv
// Loadable down counter with a zero flag; it holds at zero rather than wrapping.
//   CLK, RST  : clock, synchronous active-high reset (count -> 0)
//   load      : load load_val (has priority over dec)
//   load_val  : value to load
//   dec       : decrement by one when non-zero
//   zero      : count == 0
module ser_down_counter #(
   parameter int unsigned W = 3
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count;

   // Count register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial front end for the serial sequence detectors. Takes a WIDTH-bit word
// on a valid/ready handshake and shifts it out one bit per clock, optionally followed by
// a fixed number of forced idle cycles.
//   CLK, RST   : clock, synchronous active-high reset
//   in_data    : word to serialize, sampled only on accept
//   in_valid   : in_data valid, held by the source until accepted
//   in_ready   : a word can be accepted this cycle (state/counter decode only)
//   ser_out    : serial bit stream, IDLE_LEVEL when no bit is sent
//   ser_valid  : ser_out carries a data bit
//   word_done  : high during the last bit of a word
//   busy       : state is not IDLE
module word_serializer
   import word_serializer_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter bit          MSB_FIRST  = 1'b1,
   parameter bit          IDLE_LEVEL = 1'b0,
   parameter int unsigned GAP_CYCLES = 0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             word_done,
   output logic             busy
);

   localparam int unsigned   CW       = cnt_width(WIDTH);
   localparam int unsigned   GW       = cnt_width(GAP_CYCLES);
   localparam bit            HAS_GAP  = (GAP_CYCLES > 0);
   localparam logic [CW-1:0] BIT_LOAD = CW'(WIDTH - 1);
   localparam logic [GW-1:0] GAP_LOAD = HAS_GAP ? GW'(GAP_CYCLES - 1) : '0;

   ser_state_t       state;
   ser_state_t       state_nxt;
   logic [WIDTH-1:0] shift_reg;
   logic [WIDTH-1:0] shift_nxt;
   logic             bit_zero;
   logic             gap_zero;
   logic             bit_load;
   logic             bit_dec;
   logic             gap_load;
   logic             gap_dec;
   logic             last_bit;
   logic             head;
   logic             accept;

   // Bits remaining in the current word.
   ser_down_counter #(.W(CW)) u_bit_cnt (
      .CLK      (CLK),
      .RST      (RST),
      .load     (bit_load),
      .load_val (BIT_LOAD),
      .dec      (bit_dec),
      .zero     (bit_zero)
   );

   // Forced idle cycles remaining after a word.
   ser_down_counter #(.W(GW)) u_gap_cnt (
      .CLK      (CLK),
      .RST      (RST),
      .load     (gap_load),
      .load_val (GAP_LOAD),
      .dec      (gap_dec),
      .zero     (gap_zero)
   );

   // State and shift register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= ST_IDLE;
         shift_reg <= '0;
      end else begin
         state     <= state_nxt;
         shift_reg <= shift_nxt;
      end
   end

   assign head = MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0];

   // Next-state, counter control and output decode.
   always_comb begin
      state_nxt = state;
      shift_nxt = shift_reg;
      bit_load  = 1'b0;
      bit_dec   = 1'b0;
      gap_load  = 1'b0;
      gap_dec   = 1'b0;
      in_ready  = 1'b0;
      ser_out   = IDLE_LEVEL;
      ser_valid = 1'b0;
      word_done = 1'b0;
      busy      = (state != ST_IDLE);

      last_bit = (state == ST_SHIFT) && bit_zero;

      // Ready in IDLE, or on the last bit when words may run back-to-back.
      if (!RST) begin
         if (state == ST_IDLE) begin
            in_ready = 1'b1;
         end else if (last_bit && !HAS_GAP) begin
            in_ready = 1'b1;
         end
      end
      accept = in_valid && in_ready;

      if (state == ST_SHIFT) begin
         ser_out   = head;
         ser_valid = 1'b1;
         word_done = bit_zero;
      end

      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_nxt = ST_SHIFT;
               shift_nxt = in_data;
               bit_load  = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (bit_zero) begin
               if (HAS_GAP) begin
                  state_nxt = ST_GAP;
                  gap_load  = 1'b1;
               end else if (accept) begin
                  // Reload on the last bit keeps the stream free of idle bits.
                  shift_nxt = in_data;
                  bit_load  = 1'b1;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end else begin
               if (MSB_FIRST) begin
                  shift_nxt = {shift_reg[WIDTH-2:0], 1'b0};
               end else begin
                  shift_nxt = {1'b0, shift_reg[WIDTH-1:1]};
               end
               bit_dec = 1'b1;
            end
         end
         ST_GAP: begin
            if (gap_zero) begin
               state_nxt = ST_IDLE;
            end else begin
               gap_dec = 1'b1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule
